// File: rtl/wb_retire_stage_pkg.sv
// Shared pipeline package: default datapath widths and the write-back entry record.
// Stages import this so every stage agrees on the entry layout.
package wb_retire_stage_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_PC_W   = 32;
    localparam int WB_AW     = 5;
    localparam int WB_DEPTH  = 2;

    typedef struct packed {
        logic [WB_PC_W-1:0]   pc;
        logic                 gr_we;
        logic [WB_AW-1:0]     dest;
        logic [WB_DATA_W-1:0] result;
    } wb_entry_t;

endpackage

// File: rtl/wb_retire_fifo.sv
// Circular retire queue: payload storage plus head/tail/count bookkeeping.
// Push and pop arrive already qualified by the stage; flush wins over both.
module wb_retire_fifo
    import wb_retire_stage_pkg::*;
#(
    parameter int  DEPTH   = WB_DEPTH,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wr_entry,
    output entry_t        entries [DEPTH],
    output logic [PW-1:0] head_ptr,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] tail_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PW'(1);
            if (pop)  head_ptr <= head_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload is deliberately unreset; it is only observed through valid slots.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail_ptr] <= wr_entry;
    end

    assign entries = mem;

endmodule

// File: rtl/wb_retire_stage.sv
// Write-back / retire stage: queues MEM results and drains them into the regfile
// write port, with a youngest-match bypass. WB_DEBUG_TRACE_EN adds the debug_wb_* trace ports.
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int  DATA_W = WB_DATA_W,
    parameter int  PC_W   = WB_PC_W,
    parameter int  AW     = WB_AW,
    parameter int  DEPTH  = WB_DEPTH,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms2ws_valid,
    output logic              ws_allowin,
    input  logic [PC_W-1:0]   ms_pc,
    input  logic              ms_gr_we,
    input  logic [AW-1:0]     ms_dest,
    input  logic [DATA_W-1:0] ms_result,
    input  logic              rf_wready,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              ws_flush,
    output logic              ws_valid,
    output logic [CW-1:0]     ws_count,
    input  logic [AW-1:0]     byp_raddr,
    output logic              byp_hit,
    output logic [DATA_W-1:0] byp_data
`ifdef WB_DEBUG_TRACE_EN
   ,output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [AW-1:0]     debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

    wb_entry_t     entries [DEPTH];
    wb_entry_t     head;
    wb_entry_t     ms_entry;
    logic [PW-1:0] head_ptr;
    logic          push;
    logic          pop;
    logic          unused_pc;

    // Handshakes: an item transfers on a cycle where its valid and the receiver's
    // ready (ws_allowin upstream, rf_wready downstream) are both high; a held
    // item keeps its payload stable until that cycle, and ws_flush cancels both.
    assign ws_valid   = (ws_count != '0);
    assign head       = entries[head_ptr];
    assign pop        = ws_valid && (!head.gr_we || rf_wready) && !ws_flush;
    assign ws_allowin = (ws_count < CW'(DEPTH)) || pop;
    assign push       = ms2ws_valid && ws_allowin && !ws_flush;

    assign ms_entry = '{pc: ms_pc, gr_we: ms_gr_we, dest: ms_dest, result: ms_result};

    wb_retire_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (ws_flush),
        .wr_entry (ms_entry),
        .entries  (entries),
        .head_ptr (head_ptr),
        .count    (ws_count)
    );

    // Address/data are zeroed while empty so stale payload never leaks out.
    assign rf_we    = ws_valid && head.gr_we && (head.dest != '0) && !ws_flush;
    assign rf_waddr = ws_valid ? head.dest   : '0;
    assign rf_wdata = ws_valid ? head.result : '0;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PW'(i);
            if ((CW'(i) < ws_count) && entries[idx].gr_we &&
                (entries[idx].dest == byp_raddr) && (byp_raddr != '0)) begin
                byp_hit  = 1'b1;
                byp_data = entries[idx].result;
            end
        end
    end

    always_comb begin
        unused_pc = ^head.pc;
        for (int i = 0; i < DEPTH; i++) unused_pc = unused_pc ^ (^entries[i].pc);
    end

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_we    = {4{rf_we && rf_wready}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: a queue-based reference model checked every cycle,
// a vector table for retire outcomes, and directed stall/full/bypass/flush/reset sequences.
module tb_wb_retire_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              we;
        logic [AW-1:0]     dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              we;
        logic [AW-1:0]     dest;
        logic [DATA_W-1:0] data;
        logic              exp_rf_we;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              ms2ws_valid;
    logic              ws_allowin;
    logic [PC_W-1:0]   ms_pc;
    logic              ms_gr_we;
    logic [AW-1:0]     ms_dest;
    logic [DATA_W-1:0] ms_result;
    logic              rf_wready;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              ws_flush;
    logic              ws_valid;
    logic [CW-1:0]     ws_count;
    logic [AW-1:0]     byp_raddr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    int checks   = 0;
    int failures = 0;

    ent_t exp_q[$];

    always #5 clk = ~clk;

    wb_retire_stage #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .AW     (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ms2ws_valid (ms2ws_valid),
        .ws_allowin  (ws_allowin),
        .ms_pc       (ms_pc),
        .ms_gr_we    (ms_gr_we),
        .ms_dest     (ms_dest),
        .ms_result   (ms_result),
        .rf_wready   (rf_wready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .ws_flush    (ws_flush),
        .ws_valid    (ws_valid),
        .ws_count    (ws_count),
        .byp_raddr   (byp_raddr),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic we, input logic [AW-1:0] dest,
                         input logic [DATA_W-1:0] data);
        ms2ws_valid = v;
        ms_gr_we    = we;
        ms_dest     = dest;
        ms_result   = data;
        ms_pc       = 32'h1c00_0000 + {data[7:0], 2'b00};
    endtask

    // Reference model: checked at the negedge, then advanced to mirror the next posedge.
    ent_t              m_head;
    ent_t              m_new;
    int                m_cnt;
    logic              m_pop;
    logic              m_ai;
    logic              m_hit;
    logic [DATA_W-1:0] m_bd;

    always @(negedge clk) begin
        if (reset) exp_q.delete();
        m_cnt  = exp_q.size();
        m_head = (m_cnt > 0) ? exp_q[0] : '0;
        m_pop  = (m_cnt > 0) && (!m_head.we || rf_wready) && !ws_flush;
        m_ai   = (m_cnt < DEPTH) || m_pop;
        m_hit  = 1'b0;
        m_bd   = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i].we && exp_q[i].dest == byp_raddr && byp_raddr != '0) begin
                m_hit = 1'b1;
                m_bd  = exp_q[i].data;
            end
        end
        chk("ws_count", 64'(ws_count), 64'(m_cnt));
        chk("ws_valid", 64'(ws_valid), 64'(m_cnt > 0));
        chk("ws_allowin", 64'(ws_allowin), 64'(m_ai));
        chk("rf_we", 64'(rf_we), 64'((m_cnt > 0) && m_head.we && m_head.dest != '0 && !ws_flush));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_head.dest));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_head.data));
        chk("byp_hit", 64'(byp_hit), 64'(m_hit));
        chk("byp_data", 64'(byp_data), 64'(m_bd));
        if (!reset) begin
            if (ws_flush) begin
                exp_q.delete();
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (ms2ws_valid && m_ai) begin
                    m_new = '{pc: ms_pc, we: ms_gr_we, dest: ms_dest, data: ms_result};
                    exp_q.push_back(m_new);
                end
            end
        end
    end

    vec_t vecs [6];

    initial begin
        vecs[0] = '{we: 1'b1, dest: 5'd3,  data: 32'h0000_0033, exp_rf_we: 1'b1};
        vecs[1] = '{we: 1'b1, dest: 5'd0,  data: 32'hBAD0_0000, exp_rf_we: 1'b0};
        vecs[2] = '{we: 1'b0, dest: 5'd9,  data: 32'hBAD0_0009, exp_rf_we: 1'b0};
        vecs[3] = '{we: 1'b1, dest: 5'd31, data: 32'hFFFF_FFFF, exp_rf_we: 1'b1};
        vecs[4] = '{we: 1'b0, dest: 5'd0,  data: 32'h0,         exp_rf_we: 1'b0};
        vecs[5] = '{we: 1'b1, dest: 5'd1,  data: 32'h1234_5678, exp_rf_we: 1'b1};

        reset = 1'b1;
        rf_wready = 1'b0;
        ws_flush = 1'b0;
        byp_raddr = '0;
        offer(1'b0, 1'b0, '0, '0);
        #1;
        chk("allowin_in_reset", 64'(ws_allowin), 64'(1));
        repeat (3) step();
        reset = 1'b0;
        chk("allowin_after_reset", 64'(ws_allowin), 64'(1));
        chk("count_after_reset", 64'(ws_count), 64'(0));

        // Single push with the regfile port granted.
        rf_wready = 1'b1;
        offer(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        ms_pc = 32'h1c00_0000;
        chk("single_rf_we_same_cycle", 64'(rf_we), 64'(0));
        step();
        offer(1'b0, 1'b0, '0, '0);
        chk("single_rf_we", 64'(rf_we), 64'(1));
        chk("single_waddr", 64'(rf_waddr), 64'(5));
        chk("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        step();
        chk("single_count_zero", 64'(ws_count), 64'(0));

        // Table: one entry per cycle, each becomes head the following cycle.
        for (int i = 0; i < 6; i++) begin
            offer(1'b1, vecs[i].we, vecs[i].dest, vecs[i].data);
            step();
            chk($sformatf("vec%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].exp_rf_we));
            chk($sformatf("vec%0d_count", i), 64'(ws_count), 64'(1));
            if (vecs[i].exp_rf_we)
                chk($sformatf("vec%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].dest));
        end
        offer(1'b0, 1'b0, '0, '0);
        step();
        chk("vec_drain_count", 64'(ws_count), 64'(0));

        // Stall with three offers at depth two, then release.
        rf_wready = 1'b0;
        offer(1'b1, 1'b1, 5'd1, 32'hA1);
        step();
        offer(1'b1, 1'b1, 5'd2, 32'hB2);
        step();
        offer(1'b1, 1'b1, 5'd3, 32'hC3);
        step();
        chk("stall_count", 64'(ws_count), 64'(2));
        chk("stall_allowin", 64'(ws_allowin), 64'(0));
        chk("stall_waddr", 64'(rf_waddr), 64'(1));
        step();
        chk("stall_hold_we", 64'(rf_we), 64'(1));
        chk("stall_hold_waddr", 64'(rf_waddr), 64'(1));
        chk("stall_hold_wdata", 64'(rf_wdata), 64'hA1);
        rf_wready = 1'b1;
        #1;
        chk("full_pop_allowin", 64'(ws_allowin), 64'(1));
        step();
        offer(1'b0, 1'b0, '0, '0);
        chk("full_pushpop_count", 64'(ws_count), 64'(2));
        chk("order_second", 64'(rf_wdata), 64'hB2);
        step();
        chk("order_third", 64'(rf_wdata), 64'hC3);
        chk("order_count", 64'(ws_count), 64'(1));
        step();
        chk("order_drained", 64'(ws_count), 64'(0));

        // Bypass youngest match.
        rf_wready = 1'b0;
        offer(1'b1, 1'b1, 5'd7, 32'h11);
        step();
        offer(1'b1, 1'b1, 5'd7, 32'h22);
        step();
        offer(1'b0, 1'b0, '0, '0);
        byp_raddr = 5'd7;
        #1;
        chk("byp_hit7", 64'(byp_hit), 64'(1));
        chk("byp_data7", 64'(byp_data), 64'h22);
        byp_raddr = 5'd0;
        #1;
        chk("byp_hit0", 64'(byp_hit), 64'(0));
        chk("byp_data0", 64'(byp_data), 64'(0));
        byp_raddr = 5'd7;

        // Flush a full queue with a push offered.
        offer(1'b1, 1'b1, 5'd9, 32'h99);
        rf_wready = 1'b1;
        ws_flush  = 1'b1;
        #1;
        chk("flush_rf_we_gated", 64'(rf_we), 64'(0));
        step();
        ws_flush = 1'b0;
        offer(1'b0, 1'b0, '0, '0);
        chk("flush_count", 64'(ws_count), 64'(0));
        chk("flush_rf_we", 64'(rf_we), 64'(0));
        chk("flush_byp", 64'(byp_hit), 64'(0));

        // Reset in the middle of a stall.
        rf_wready = 1'b0;
        offer(1'b1, 1'b1, 5'd4, 32'h44);
        step();
        offer(1'b1, 1'b1, 5'd7, 32'h77);
        step();
        offer(1'b0, 1'b0, '0, '0);
        chk("prereset_count", 64'(ws_count), 64'(2));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(ws_valid), 64'(0));
        chk("async_reset_rf_we", 64'(rf_we), 64'(0));
        chk("async_reset_byp", 64'(byp_hit), 64'(0));
        chk("async_reset_allowin", 64'(ws_allowin), 64'(1));
        step();
        reset = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            offer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), $urandom);
            ms_pc     = $urandom;
            rf_wready = 1'($urandom_range(0, 2) != 0);
            ws_flush  = 1'($urandom_range(0, 15) == 0);
            byp_raddr = 5'($urandom_range(0, 7));
            step();
        end
        offer(1'b0, 1'b0, '0, '0);
        ws_flush  = 1'b0;
        rf_wready = 1'b1;
        repeat (4) step();
        chk("final_drained", 64'(ws_count), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
